// File: rtl/qea_pkg.sv
// qea_pkg: run-controller FSM states and the fixed-point ONE shared across the QEA slice.
package qea_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD_CTX   = 3'd1,
    INIT_STATE = 3'd2,
    START      = 3'd3,
    WAIT_CMPL  = 3'd4,
    RD_REQ     = 3'd5,
    RD_WAIT    = 3'd6,
    DONE       = 3'd7
  } qea_run_state_e;

  localparam int unsigned QEA_NUM_FRAC_BIT = 30;
  localparam logic [63:0] QEA_FX_ONE       = 64'd1 << QEA_NUM_FRAC_BIT;

  // Fixed-point 1.0 for an arbitrary fraction width.
  function automatic logic [63:0] qea_fx_one(input int unsigned frac_bits);
    return 64'd1 << frac_bits;
  endfunction

endpackage

// File: rtl/qea_rd_buf.sv
// qea_rd_buf: readout holding register; data stays stable while valid is high and the sink stalls.
module qea_rd_buf
  import qea_pkg::*;
#(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Load wins over the handshake; a completed handshake drops valid.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (i_load) begin
      valid_d = 1'b1;
      data_d  = i_data;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= {WIDTH{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;

endmodule

// File: rtl/qea_run_ctrl.sv
// qea_run_ctrl: loads ctx RAM, initialises state RAM, runs the QEA and streams the state back out.
// Define QEA_RUN_CYCLE_COUNT_EN to build the WAIT_CMPL cycle counter on o_cycle_count.
module qea_run_ctrl
  import qea_pkg::*;
#(
  parameter int PE_NUM_WIDTH            = 2,
  parameter int PE_NUM                  = 4,
  parameter int DATA_WIDTH              = 32,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int NUM_FRAC_BIT            = QEA_NUM_FRAC_BIT
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_run,
  input  logic [MAX_QBIT_WIDTH-1:0]          i_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH:0]   i_ins_num,
  input  logic                               i_ctx_valid,
  input  logic [2*DATA_WIDTH-1:0]            i_ctx_data,
  output logic                               o_ctx_ready,
  output logic                               o_ctx_en,
  output logic                               o_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0] o_ctx_addr,
  output logic [2*DATA_WIDTH-1:0]            o_ctx_data,
  output logic                               o_state_ena,
  output logic                               o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]        o_state_addra,
  output logic [PE_NUM*2*DATA_WIDTH-1:0]     o_state_dina,
  input  logic [PE_NUM*2*DATA_WIDTH-1:0]     i_state_dout,
  output logic                               o_qea_start,
  output logic [MAX_QBIT_WIDTH-1:0]          o_qbit_num,
  input  logic                               i_qea_complete,
  output logic                               o_rd_valid,
  output logic [PE_NUM*2*DATA_WIDTH-1:0]     o_rd_data,
  input  logic                               i_rd_ready,
  output logic                               o_busy,
  output logic                               o_done,
  output logic                               o_err,
  output logic [31:0]                        o_cycle_count
);

  localparam int SW = PE_NUM * 2 * DATA_WIDTH;
  localparam int IW = GATE_CONTEXT_ADDR_WIDTH + 1;
  localparam int AW = STATE_ADDR_WIDTH;
  localparam logic [MAX_QBIT_WIDTH-1:0] QBIT_LO = MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
  localparam logic [MAX_QBIT_WIDTH-1:0] QBIT_HI = MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH + PE_NUM_WIDTH);
  localparam logic [DATA_WIDTH-1:0]     ONE     = DATA_WIDTH'(qea_fx_one(NUM_FRAC_BIT));
  // Real part sits in the upper half of each PE slot, so ONE lands in the top bits of the word.
  localparam logic [SW-1:0]             INIT_WORD = {ONE, {(SW-DATA_WIDTH){1'b0}}};

  qea_run_state_e              state_q, state_d;
  logic [MAX_QBIT_WIDTH-1:0]   qbit_q, qbit_d;
  logic [IW-1:0]               ins_q, ins_d, ctx_cnt_q, ctx_cnt_d;
  logic [AW-1:0]               last_q, last_d, st_addr_q, st_addr_d;
  logic [SW-1:0]               st_din_q, st_din_d;
  logic                        ctx_ready_q, ctx_ready_d, st_ena_q, st_ena_d, st_wea_q, st_wea_d;
  logic                        start_q, start_d, skip_q, skip_d, rd_pend_q, rd_pend_d;
  logic                        busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                        qbit_ok_s, ctx_acc_s, rd_load_s, rd_valid_s;
  logic [AW-1:0]               last_addr_s;

  assign qbit_ok_s   = (i_qbit_num > QBIT_LO) && (i_qbit_num <= QBIT_HI);
  // N = 2**(qbit-PE_NUM_WIDTH); for N = 2**AW the shift wraps to 0 and N-1 is still all ones.
  assign last_addr_s = (AW'(1) << (i_qbit_num - QBIT_LO)) - AW'(1);
  assign ctx_acc_s   = ctx_ready_q & i_ctx_valid;
  assign rd_load_s   = (state_q == RD_WAIT) && !rd_pend_q;

  // Next-state and next-output logic for the run sequence.
  always_comb begin
    state_d     = state_q;
    qbit_d      = qbit_q;
    ins_d       = ins_q;
    last_d      = last_q;
    ctx_cnt_d   = ctx_cnt_q;
    ctx_ready_d = 1'b0;
    st_ena_d    = 1'b0;
    st_wea_d    = 1'b0;
    st_addr_d   = st_addr_q;
    st_din_d    = {SW{1'b0}};
    start_d     = 1'b0;
    skip_d      = 1'b0;
    rd_pend_d   = rd_pend_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_run) begin
          qbit_d = i_qbit_num;
          if (qbit_ok_s) begin
            ins_d     = i_ins_num;
            last_d    = last_addr_s;
            ctx_cnt_d = {IW{1'b0}};
            if (i_ins_num == {IW{1'b0}}) begin
              state_d   = INIT_STATE;
              st_ena_d  = 1'b1;
              st_wea_d  = 1'b1;
              st_addr_d = {AW{1'b0}};
              st_din_d  = INIT_WORD;
            end else begin
              state_d     = LOAD_CTX;
              ctx_ready_d = 1'b1;
            end
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD_CTX: begin
        ctx_ready_d = 1'b1;
        if (ctx_acc_s) begin
          ctx_cnt_d = ctx_cnt_q + IW'(1);
          if (ctx_cnt_d == ins_q) begin
            ctx_ready_d = 1'b0;
            state_d     = INIT_STATE;
            st_ena_d    = 1'b1;
            st_wea_d    = 1'b1;
            st_addr_d   = {AW{1'b0}};
            st_din_d    = INIT_WORD;
          end else begin
            state_d = LOAD_CTX;
          end
        end else begin
          ctx_cnt_d = ctx_cnt_q;
        end
      end
      INIT_STATE: begin
        if (st_addr_q == last_q) begin
          state_d   = START;
          start_d   = 1'b1;
          st_addr_d = {AW{1'b0}};
        end else begin
          st_ena_d  = 1'b1;
          st_wea_d  = 1'b1;
          st_addr_d = st_addr_q + AW'(1);
        end
      end
      START: begin
        state_d = WAIT_CMPL;
        skip_d  = 1'b1;
      end
      WAIT_CMPL: begin
        if (!skip_q && i_qea_complete) begin
          state_d   = RD_REQ;
          st_ena_d  = 1'b1;
          st_addr_d = {AW{1'b0}};
        end else begin
          state_d = WAIT_CMPL;
        end
      end
      RD_REQ: begin
        state_d   = RD_WAIT;
        rd_pend_d = 1'b0;
      end
      RD_WAIT: begin
        if (!rd_pend_q) begin
          rd_pend_d = 1'b1;
        end else if (rd_valid_s && i_rd_ready) begin
          rd_pend_d = 1'b0;
          if (st_addr_q == last_q) begin
            state_d   = DONE;
            done_d    = 1'b1;
            st_addr_d = {AW{1'b0}};
          end else begin
            state_d   = RD_REQ;
            st_ena_d  = 1'b1;
            st_addr_d = st_addr_q + AW'(1);
          end
        end else begin
          state_d = RD_WAIT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      qbit_q      <= {MAX_QBIT_WIDTH{1'b0}};
      ins_q       <= {IW{1'b0}};
      last_q      <= {AW{1'b0}};
      ctx_cnt_q   <= {IW{1'b0}};
      ctx_ready_q <= 1'b0;
      st_ena_q    <= 1'b0;
      st_wea_q    <= 1'b0;
      st_addr_q   <= {AW{1'b0}};
      st_din_q    <= {SW{1'b0}};
      start_q     <= 1'b0;
      skip_q      <= 1'b0;
      rd_pend_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      qbit_q      <= qbit_d;
      ins_q       <= ins_d;
      last_q      <= last_d;
      ctx_cnt_q   <= ctx_cnt_d;
      ctx_ready_q <= ctx_ready_d;
      st_ena_q    <= st_ena_d;
      st_wea_q    <= st_wea_d;
      st_addr_q   <= st_addr_d;
      st_din_q    <= st_din_d;
      start_q     <= start_d;
      skip_q      <= skip_d;
      rd_pend_q   <= rd_pend_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  qea_rd_buf #(.WIDTH(SW)) u_rd_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (rd_load_s),
    .i_data  (i_state_dout),
    .i_ready (i_rd_ready),
    .o_valid (rd_valid_s),
    .o_data  (o_rd_data)
  );

`ifdef QEA_RUN_CYCLE_COUNT_EN
  logic [31:0] cyc_q, cyc_d;

  // Cleared on the start pulse, counts WAIT_CMPL cycles, then holds.
  always_comb begin
    cyc_d = cyc_q;
    if (state_q == START) begin
      cyc_d = 32'd0;
    end else if (state_q == WAIT_CMPL) begin
      cyc_d = cyc_q + 32'd1;
    end else begin
      cyc_d = cyc_q;
    end
  end

  // Cycle counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= 32'd0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign o_cycle_count = cyc_q;
`else
  assign o_cycle_count = 32'd0;
`endif

  // Ctx writes follow the handshake in the same cycle.
  assign o_ctx_ready   = ctx_ready_q;
  assign o_ctx_en      = ctx_acc_s;
  assign o_ctx_wea     = ctx_acc_s;
  assign o_ctx_addr    = ctx_cnt_q[GATE_CONTEXT_ADDR_WIDTH-1:0];
  assign o_ctx_data    = ctx_acc_s ? i_ctx_data : {(2*DATA_WIDTH){1'b0}};
  assign o_state_ena   = st_ena_q;
  assign o_state_wea   = st_wea_q;
  assign o_state_addra = st_addr_q;
  assign o_state_dina  = st_din_q;
  assign o_qea_start   = start_q;
  assign o_qbit_num    = qbit_q;
  assign o_rd_valid    = rd_valid_s;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_err         = err_q;

endmodule
